// File: rtl/bg_pkg.sv
// Shared constants, FSM state type and modular-add helper for the background
// scroll controller and its address generator.
package bg_pkg;

  localparam int unsigned IMG_W   = 500;  // source image width (texels)
  localparam int unsigned IMG_H   = 500;  // source image height (texels)
  localparam int unsigned SCR_W   = 640;  // visible screen width (pixels)
  localparam int unsigned SCR_H   = 480;  // visible screen height (pixels)
  localparam int unsigned ADDR_W  = 18;   // background ROM address width
  localparam int unsigned SPEED_W = 4;    // scroll speed width
  localparam int unsigned COORD_W = 10;   // DrawX/DrawY width
  localparam int unsigned TEX_W   = 9;    // texel coordinate / scroll width
  localparam int unsigned MOD_W   = TEX_W + 1;
  localparam int unsigned PIX_W   = 4;    // palette index width

  typedef enum logic [2:0] {
    S_PIX,
    S_PADDR,
    S_PWAIT,
    S_PCAP,
    S_PACK
  } bg_state_t;

  // (a + b) mod m with a single conditional subtract; callers keep a, b < m.
  function automatic logic [TEX_W-1:0] wrap_add(input logic [TEX_W-1:0] a,
                                                input logic [TEX_W-1:0] b,
                                                input logic [MOD_W-1:0] m);
    logic [MOD_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= m) ? TEX_W'(s - m) : TEX_W'(s);
  endfunction

endpackage

// File: rtl/bg_probe_if.sv
// Probe handshake between the collision/probe requester and the controller.
//   probe_req  : request, held by the requester until probe_ack
//   probe_x/y  : probe texel column (screen-relative, pre-scroll) and row
//   probe_ack  : one-cycle pulse, probe_data valid in the same cycle
//   probe_data : palette index at the probe point
interface bg_probe_if;
  import bg_pkg::*;

  logic             probe_req;
  logic [TEX_W-1:0] probe_x;
  logic [TEX_W-1:0] probe_y;
  logic             probe_ack;
  logic [PIX_W-1:0] probe_data;

  modport master (output probe_req, probe_x, probe_y,
                  input  probe_ack, probe_data);

  modport slave  (input  probe_req, probe_x, probe_y,
                  output probe_ack, probe_data);
endinterface

// File: rtl/bg_addr_gen.sv
// Scale, scroll and linearise a texel coordinate into a registered ROM address.
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture a new address (otherwise hold)
//   sel           : 0 = pixel path (draw_x/draw_y), 1 = probe path
//   draw_x/draw_y : screen pixel coordinate
//   probe_x/y     : probe texel coordinate
//   scroll        : horizontal scroll offset applied to the column
//   addr          : registered ROM address
module bg_addr_gen
  import bg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               sel,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [TEX_W-1:0]   probe_x,
  input  logic [TEX_W-1:0]   probe_y,
  input  logic [TEX_W-1:0]   scroll,
  output logic [ADDR_W-1:0]  addr
);

  localparam int unsigned MUL_W = 20;

  logic [MUL_W-1:0] x_div, y_div;
  logic [TEX_W-1:0] x_tex, y_tex, col, row, sx;

  always_comb begin
    x_div = (MUL_W'(draw_x) * MUL_W'(IMG_W)) / MUL_W'(SCR_W);
    y_div = (MUL_W'(draw_y) * MUL_W'(IMG_H)) / MUL_W'(SCR_H);
    // Blanking-region coordinates scale past the image; clamp so the
    // address stays inside the ROM (those pixels are zeroed downstream).
    x_tex = (x_div >= MUL_W'(IMG_W)) ? TEX_W'(IMG_W - 1) : TEX_W'(x_div);
    y_tex = (y_div >= MUL_W'(IMG_H)) ? TEX_W'(IMG_H - 1) : TEX_W'(y_div);
    col   = sel ? probe_x : x_tex;
    row   = sel ? probe_y : y_tex;
    sx    = wrap_add(col, scroll, MOD_W'(IMG_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(sx);
    end
  end

endmodule

// File: rtl/background_scroll_ctrl.sv
// Background ROM access sequencer: scaled/scrolled pixel addressing for the
// VGA path, probe reads during blanking, per-frame scroll update.
// Latency DrawX/DrawY -> pix_index is 3 cycles (address reg, ROM, output reg).
//   vga_clk, Reset : pixel clock, synchronous active-high reset
//   DrawX, DrawY   : current pixel; blank = 1 during active video
//   frame_tick     : once-per-frame pulse; pause freezes scroll; speed = step
//   probe          : probe handshake (slave side)
//   rom_address    : to background_rom; rom_q = 1-cycle synchronous read data
//   pix_index      : palette index for the pixel path
//   scroll_x       : committed scroll offset
module background_scroll_ctrl
  import bg_pkg::*;
(
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic [SPEED_W-1:0] speed,
  bg_probe_if.slave          probe,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [PIX_W-1:0]   rom_q,
  output logic [PIX_W-1:0]   pix_index,
  output logic [TEX_W-1:0]   scroll_x
);

  bg_state_t        state;
  logic [TEX_W-1:0] scroll_cur;
  logic [TEX_W-1:0] scroll_next_c;
  logic             vis_q1, vis_q2;
  logic             probe_y_bad_c, probe_sel_c, addr_load_c;

  assign probe_y_bad_c = probe.probe_y >= TEX_W'(IMG_H);
  assign probe_sel_c   = (state == S_PADDR) && !blank;
  // Active video always reclaims the ROM; otherwise the probe address is held
  // through its read, and an out-of-range probe issues nothing.
  assign addr_load_c   = blank || !(((state == S_PADDR) && probe_y_bad_c) ||
                                    (state == S_PWAIT) || (state == S_PCAP));
  assign scroll_next_c = wrap_add(scroll_x, TEX_W'(speed), MOD_W'(IMG_W));

  bg_addr_gen u_addr_gen (
    .clk     (vga_clk),
    .rst     (Reset),
    .load    (addr_load_c),
    .sel     (probe_sel_c),
    .draw_x  (DrawX),
    .draw_y  (DrawY),
    .probe_x (probe.probe_x),
    .probe_y (probe.probe_y),
    .scroll  (scroll_cur),
    .addr    (rom_address)
  );

  // Scroll commits only at frame_tick, so scroll_cur is stable all frame.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      scroll_x   <= '0;
      scroll_cur <= '0;
    end else if (frame_tick && !pause) begin
      scroll_x   <= scroll_next_c;
      scroll_cur <= scroll_next_c;
    end
  end

  // Pixel output; visibility flag travels alongside the address and ROM read.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      vis_q1    <= 1'b0;
      vis_q2    <= 1'b0;
      pix_index <= '0;
    end else begin
      vis_q1    <= blank;
      vis_q2    <= vis_q1;
      pix_index <= vis_q2 ? rom_q : '0;
    end
  end

  // Probe FSM: runs only in blanking, aborts silently when video resumes.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state            <= S_PIX;
      probe.probe_ack  <= 1'b0;
      probe.probe_data <= '0;
    end else begin
      probe.probe_ack <= 1'b0;
      unique case (state)
        S_PIX: begin
          if (!blank && probe.probe_req) state <= S_PADDR;
        end
        S_PADDR: begin
          if (blank) begin
            state <= S_PIX;
          end else if (probe_y_bad_c) begin
            probe.probe_data <= '0;
            probe.probe_ack  <= probe.probe_req;
            state            <= S_PACK;
          end else begin
            state <= S_PWAIT;
          end
        end
        S_PWAIT: begin
          state <= blank ? S_PIX : S_PCAP;
        end
        S_PCAP: begin
          if (blank) begin
            state <= S_PIX;
          end else begin
            probe.probe_data <= rom_q;
            probe.probe_ack  <= probe.probe_req;
            state            <= S_PACK;
          end
        end
        S_PACK: begin
          state <= S_PIX;
        end
        default: begin
          state <= S_PIX;
        end
      endcase
    end
  end

endmodule
